// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot grant, binary index and owner lock.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD owner cycles when others are waiting.
module rr_arbiter8 #(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_valid,
    output logic                 timeout
);

    localparam int unsigned IDXW = $clog2(N);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [N-1:0]    cand;
    logic [IDXW-1:0] scan_idx;
    logic [IDXW-1:0] win_idx;
    logic            win_found;
    logic            owner_req;
    logic            take_win;

    function automatic logic [IDXW-1:0] onehot_to_bin(input logic [N-1:0] oh);
        logic [IDXW-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (oh[i]) b = b | IDXW'(i);
        end
        return b;
    endfunction

    // The current owner is never a candidate, so a timed-out owner loses to the others.
    always_comb begin
        cand      = req & ~gnt_q;
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            scan_idx = ptr_q + IDXW'(k);
            if (!win_found && cand[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign owner_req = |(req & gnt_q);

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HoldW = $clog2(MAX_HOLD);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             timeout_q, timeout_d;
`else
    logic unused_max_hold;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        take_win = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (win_found) take_win = 1'b1;
            end
            StBusy: begin
                if (!owner_req) begin
                    if (win_found) begin
                        take_win = 1'b1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HoldMax) begin
                    // Saturated: release only if someone else is waiting.
                    if (win_found) begin
                        take_win  = 1'b1;
                        timeout_d = 1'b1;
                    end
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
`endif
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase

        if (take_win) begin
            state_d = StBusy;
            gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
            ptr_d   = win_idx + IDXW'(1);
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
        end
        idx_d = onehot_to_bin(gnt_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;

endmodule
